// File: rtl/fir_filter_bank.sv
// Time-multiplexed FIR filter bank: one serial MAC computes LPF, HPF, LP->HP
// cascade (BPF) or LP+HP sum (BSF) per sample from two loadable coefficient banks.
module fir_filter_bank #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int OUT_W  = 16,
    parameter int TAPS   = 16,
    parameter int FRAC   = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        i_in_data,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [1:0]               i_mode,
    input  logic                     i_coef_we,
    input  logic                     i_coef_bank,
    input  logic [$clog2(TAPS)-1:0]  i_coef_addr,
    input  logic [COEF_W-1:0]        i_coef_data,
    input  logic                     i_flush,
    output logic [OUT_W-1:0]         o_out_data,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic                     o_busy
);
    localparam int AW     = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = DATA_W + COEF_W + AW;
    localparam logic [1:0] M_LPF = 2'd0;
    localparam logic [1:0] M_HPF = 2'd1;
    localparam logic [1:0] M_BPF = 2'd2;
    localparam logic [1:0] M_BSF = 2'd3;
    localparam logic signed [ACC_W-1:0] D_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] D_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] O_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] O_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MAC_A, S_MAC_B, S_OUT} state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic signed [DATA_W-1:0]  r_x  [TAPS];
    logic signed [DATA_W-1:0]  r_lp [TAPS];
    logic signed [COEF_W-1:0]  r_h0 [TAPS];
    logic signed [COEF_W-1:0]  r_h1 [TAPS];
    logic [1:0]                r_mode;
    logic signed [ACC_W-1:0]   r_acc;
    logic [AW-1:0]             r_tap;
    logic signed [DATA_W-1:0]  r_a;
    logic [OUT_W-1:0]          r_out_data;

    logic                      w_idle;
    logic                      w_accept;
    logic                      w_flush;
    logic                      w_coef_wr;
    logic                      w_last;
    logic                      w_use_hp;
    logic signed [COEF_W-1:0]  w_coef;
    logic signed [DATA_W-1:0]  w_data;
    logic signed [PROD_W-1:0]  w_prod;
    logic signed [ACC_W-1:0]   w_acc_sum;
    logic signed [ACC_W-1:0]   w_shift;
    logic signed [DATA_W-1:0]  w_stage;
    logic signed [DATA_W:0]    w_bsf_sum;
    logic signed [ACC_W-1:0]   w_bsf_ext;
    logic [OUT_W-1:0]          w_result;

    function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] c;
        c = (v > D_MAX) ? D_MAX : ((v < D_MIN) ? D_MIN : v);
        return c[DATA_W-1:0];
    endfunction

    function automatic logic [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] c;
        c = (v > O_MAX) ? O_MAX : ((v < O_MIN) ? O_MIN : v);
        return c[OUT_W-1:0];
    endfunction

    assign w_idle    = (r_state == S_IDLE);
    assign w_flush   = w_idle && i_flush;
    assign w_accept  = w_idle && i_in_valid && !i_flush;
    assign w_coef_wr = w_idle && i_coef_we;
    assign w_last    = (r_tap == AW'(TAPS - 1));

    // Second pass always uses the HP bank; BPF's second pass walks the lp line.
    assign w_use_hp  = (r_state == S_MAC_B) || (r_mode == M_HPF);
    assign w_coef    = w_use_hp ? r_h1[r_tap] : r_h0[r_tap];
    assign w_data    = ((r_state == S_MAC_B) && (r_mode == M_BPF)) ? r_lp[r_tap] : r_x[r_tap];
    assign w_prod    = w_coef * w_data;
    assign w_acc_sum = r_acc + {{AW{w_prod[PROD_W-1]}}, w_prod};
    assign w_shift   = w_acc_sum >>> FRAC;
    assign w_stage   = sat_data(w_shift);
    assign w_bsf_sum = {r_a[DATA_W-1], r_a} + {w_stage[DATA_W-1], w_stage};
    assign w_bsf_ext = {{(ACC_W-DATA_W-1){w_bsf_sum[DATA_W]}}, w_bsf_sum};
    assign w_result  = ((r_state == S_MAC_B) && (r_mode == M_BSF)) ? sat_out(w_bsf_ext)
                                                                     : sat_out(w_shift);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_MAC_A;
            S_MAC_A: if (w_last) w_state_next = ((r_mode == M_LPF) || (r_mode == M_HPF)) ? S_OUT : S_MAC_B;
            S_MAC_B: if (w_last) w_state_next = S_OUT;
            S_OUT:   if (i_out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                r_x[k]  <= '0;
                r_lp[k] <= '0;
                r_h0[k] <= '0;
                r_h1[k] <= '0;
            end
            r_mode     <= M_LPF;
            r_acc      <= '0;
            r_tap      <= '0;
            r_a        <= '0;
            r_out_data <= '0;
        end else begin
            if (w_coef_wr) begin
                if (i_coef_bank) r_h1[i_coef_addr] <= i_coef_data;
                else             r_h0[i_coef_addr] <= i_coef_data;
            end
            if (w_flush) begin
                for (int k = 0; k < TAPS; k++) begin
                    r_x[k]  <= '0;
                    r_lp[k] <= '0;
                end
            end else if (w_accept) begin
                for (int k = TAPS - 1; k > 0; k--) r_x[k] <= r_x[k-1];
                r_x[0] <= i_in_data;
            end
            // The lp line carries LP-stage history and advances only on BPF samples.
            if ((r_state == S_MAC_A) && w_last && (r_mode == M_BPF)) begin
                for (int k = TAPS - 1; k > 0; k--) r_lp[k] <= r_lp[k-1];
                r_lp[0] <= w_stage;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mode <= i_mode;
                        r_acc  <= '0;
                        r_tap  <= '0;
                    end
                end
                S_MAC_A: begin
                    r_acc <= w_acc_sum;
                    r_tap <= r_tap + AW'(1);
                    if (w_last) begin
                        r_tap <= '0;
                        if ((r_mode == M_LPF) || (r_mode == M_HPF)) begin
                            r_out_data <= w_result;
                        end else begin
                            r_a   <= w_stage;
                            r_acc <= '0;
                        end
                    end
                end
                S_MAC_B: begin
                    r_acc <= w_acc_sum;
                    r_tap <= r_tap + AW'(1);
                    if (w_last) begin
                        r_tap      <= '0;
                        r_out_data <= w_result;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_in_ready  = w_idle;
    assign o_busy      = !w_idle;
    assign o_out_valid = (r_state == S_OUT);
    assign o_out_data  = r_out_data;

endmodule

// File: tb/tb_fir_filter_bank.sv
// Bench for fir_filter_bank: directed vector table plus randomized samples checked
// against an arithmetic convolution model of the four filter modes.
module tb_fir_filter_bank;
    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int OUT_W  = 16;
    localparam int TAPS   = 16;
    localparam int FRAC   = 15;
    localparam int AW     = $clog2(TAPS);

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] i_in_data;
    logic              i_in_valid;
    logic              o_in_ready;
    logic [1:0]        i_mode;
    logic              i_coef_we;
    logic              i_coef_bank;
    logic [AW-1:0]     i_coef_addr;
    logic [COEF_W-1:0] i_coef_data;
    logic              i_flush;
    logic [OUT_W-1:0]  o_out_data;
    logic              o_out_valid;
    logic              i_out_ready;
    logic              o_busy;

    fir_filter_bank #(.DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W), .TAPS(TAPS), .FRAC(FRAC)) dut (
        .clk(clk), .rst(rst),
        .i_in_data(i_in_data), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .i_mode(i_mode), .i_coef_we(i_coef_we), .i_coef_bank(i_coef_bank),
        .i_coef_addr(i_coef_addr), .i_coef_data(i_coef_data), .i_flush(i_flush),
        .o_out_data(o_out_data), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mode;
        int din;
        int exp;
    } vec_t;

    vec_t tab [9];
    int   n_checks = 0;
    int   n_errors = 0;
    int   mh  [2][TAPS];
    int   mx  [TAPS];
    int   mlp [TAPS];

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int sat(input longint v, input int w);
        longint hi = (longint'(1) <<< (w - 1)) - 1;
        longint lo = -hi - 1;
        return int'((v > hi) ? hi : ((v < lo) ? lo : v));
    endfunction

    function automatic longint conv(input int bank, input bit use_lp);
        longint s = 0;
        for (int k = 0; k < TAPS; k++)
            s += longint'(mh[bank][k]) * longint'(use_lp ? mlp[k] : mx[k]);
        return s >>> FRAC;
    endfunction

    task automatic model_clear_lines();
        for (int k = 0; k < TAPS; k++) begin
            mx[k]  = 0;
            mlp[k] = 0;
        end
    endtask

    task automatic model_reset();
        model_clear_lines();
        for (int k = 0; k < TAPS; k++) begin
            mh[0][k] = 0;
            mh[1][k] = 0;
        end
    endtask

    task automatic model_step(input int mode, input int din, output int exp);
        int a, b;
        for (int k = TAPS - 1; k > 0; k--) mx[k] = mx[k-1];
        mx[0] = din;
        case (mode)
            0: exp = sat(conv(0, 1'b0), OUT_W);
            1: exp = sat(conv(1, 1'b0), OUT_W);
            2: begin
                a = sat(conv(0, 1'b0), DATA_W);
                for (int k = TAPS - 1; k > 0; k--) mlp[k] = mlp[k-1];
                mlp[0] = a;
                exp = sat(conv(1, 1'b1), OUT_W);
            end
            default: begin
                a = sat(conv(0, 1'b0), DATA_W);
                b = sat(conv(1, 1'b0), DATA_W);
                exp = sat(longint'(a + b), OUT_W);
            end
        endcase
    endtask

    task automatic write_coef(input int bank, input int addr, input int data);
        i_coef_we   = 1'b1;
        i_coef_bank = bank[0];
        i_coef_addr = AW'(addr);
        i_coef_data = COEF_W'(data);
        @(posedge clk); #1;
        i_coef_we = 1'b0;
        mh[bank][addr] = sat(longint'(data), COEF_W);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
    endtask

    // Called #1 after a rising edge with the DUT in IDLE and out_ready high.
    task automatic send(input int mode, input int din, input bit use_tab, input int tab_exp);
        int exp;
        int lat;
        model_step(mode, din, exp);
        chk("in_ready_before_sample", int'(o_in_ready), 1);
        i_in_valid = 1'b1;
        i_in_data  = DATA_W'(din);
        i_mode     = 2'(mode);
        @(posedge clk); #1;
        i_in_valid = 1'b0;
        i_in_data  = DATA_W'($urandom);
        i_mode     = 2'($urandom);
        lat = 0;
        while (!o_out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("latency mode%0d", mode), lat, (mode >= 2) ? 2 * TAPS : TAPS);
        chk($sformatf("model mode%0d in=%0d", mode, din), int'($signed(o_out_data)), exp);
        if (use_tab) chk($sformatf("table mode%0d in=%0d", mode, din), int'($signed(o_out_data)), tab_exp);
        $display("sample mode=%0d in=%0d out=%0d expected=%0d latency=%0d", mode, din,
                 int'($signed(o_out_data)), exp, lat);
        @(posedge clk); #1;
        chk("out_valid_drop", int'(o_out_valid), 0);
        chk("in_ready_return", int'(o_in_ready), 1);
    endtask

    task automatic load_random_coefs();
        for (int b = 0; b < 2; b++)
            for (int k = 0; k < TAPS; k++)
                write_coef(b, k, int'($urandom_range(0, 8191)) - 4096);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int held;
        int exp;
        tab[0] = '{0, 1000, 500};
        tab[1] = '{0, 0, 500};
        tab[2] = '{0, 0, 500};
        tab[3] = '{0, 0, 500};
        tab[4] = '{0, 0, 0};
        tab[5] = '{1, 1000, 999};
        tab[6] = '{1, -1000, -1000};
        tab[7] = '{2, 1000, 250};
        tab[8] = '{3, 1000, 1000};

        rst = 1'b1; i_in_data = '0; i_in_valid = 1'b0; i_mode = '0; i_coef_we = 1'b0;
        i_coef_bank = 1'b0; i_coef_addr = '0; i_coef_data = '0; i_flush = 1'b0; i_out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_data", int'(o_out_data), 0);
        chk("reset out_valid", int'(o_out_valid), 0);
        chk("reset in_ready", int'(o_in_ready), 1);
        chk("reset busy", int'(o_busy), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // LPF impulse, then HPF truncation
        for (int k = 0; k < 4; k++) write_coef(0, k, 16'h4000);
        for (int i = 0; i < 5; i++) send(tab[i].mode, tab[i].din, 1'b1, tab[i].exp);
        write_coef(1, 0, 16'h7FFF);
        for (int i = 5; i < 7; i++) send(tab[i].mode, tab[i].din, 1'b1, tab[i].exp);

        // Saturation in both directions
        for (int k = 0; k < TAPS; k++) write_coef(0, k, 16'h7FFF);
        for (int i = 0; i < TAPS; i++) send(0, 32767, (i == TAPS - 1), 32767);
        for (int i = 0; i < TAPS; i++) send(0, -32768, (i == TAPS - 1), -32768);

        // BPF / BSF cascade
        do_reset();
        write_coef(0, 0, 16'h4000);
        write_coef(1, 0, 16'h4000);
        for (int i = 7; i < 9; i++) send(tab[i].mode, tab[i].din, 1'b1, tab[i].exp);

        // Randomized samples and modes
        load_random_coefs();
        for (int i = 0; i < 40; i++)
            send(int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)) - 32768, 1'b0, 0);

        // Backpressure with ignored sample and coefficient write while busy
        i_out_ready = 1'b0;
        model_step(1, 12345, exp);
        i_in_valid = 1'b1; i_in_data = DATA_W'(12345); i_mode = 2'd1;
        @(posedge clk); #1;
        i_in_valid = 1'b0;
        for (int n = 0; n < 100 && !o_out_valid; n++) begin
            @(posedge clk); #1;
        end
        held = int'($signed(o_out_data));
        chk("backpressure result", held, exp);
        for (int c = 0; c < 10; c++) begin
            i_in_valid = 1'b1; i_in_data = DATA_W'($urandom); i_mode = 2'($urandom);
            i_coef_we = 1'b1; i_coef_bank = c[0]; i_coef_addr = AW'(c); i_coef_data = 16'h1234;
            @(posedge clk); #1;
            chk("backpressure out_data stable", int'($signed(o_out_data)), held);
            chk("backpressure out_valid", int'(o_out_valid), 1);
            chk("backpressure in_ready", int'(o_in_ready), 0);
        end
        i_in_valid = 1'b0; i_coef_we = 1'b0; i_out_ready = 1'b1;
        @(posedge clk); #1;
        chk("backpressure release", int'(o_out_valid), 0);
        for (int i = 0; i < 4; i++) send(i, int'($urandom_range(0, 65535)) - 32768, 1'b0, 0);

        // Reset in the middle of MAC_B
        i_in_valid = 1'b1; i_in_data = DATA_W'(1000); i_mode = 2'd2;
        @(posedge clk); #1;
        i_in_valid = 1'b0;
        repeat (TAPS + 4) @(posedge clk);
        #1;
        chk("busy before mid reset", int'(o_busy), 1);
        rst = 1'b1;
        #1;
        chk("mid reset out_valid", int'(o_out_valid), 0);
        chk("mid reset in_ready", int'(o_in_ready), 1);
        chk("mid reset busy", int'(o_busy), 0);
        chk("mid reset out_data", int'(o_out_data), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        send(0, 1000, 1'b1, 0);
        load_random_coefs();
        send(2, 1000, 1'b0, 0);

        // Flush beats a simultaneous sample
        for (int i = 0; i < 3; i++) send(2, int'($urandom_range(0, 65535)) - 32768, 1'b0, 0);
        i_flush = 1'b1; i_in_valid = 1'b1; i_in_data = DATA_W'(777); i_mode = 2'd0;
        @(posedge clk); #1;
        i_flush = 1'b0; i_in_valid = 1'b0;
        chk("flush wins in_ready", int'(o_in_ready), 1);
        model_clear_lines();
        send(2, 1000, 1'b0, 0);
        send(3, -2000, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
